reg_write_arbiter: RTL and testbench

- Round-robin arbiter sharing the single write port of the 8-bit CPU register bank between up to N_REQ write sources (e.g. ALU writeback, memory load, immediate load).
- Each source raises a request carrying address and data. The arbiter picks one winner per cycle and drives the bank's write enable, address and data from registers. It returns a one-cycle ack to the winner.
- Sits between the datapath write sources and the register bank (whose per-register enable/d_in inputs are decoded from wr_en/wr_addr/wr_data).

---
 rtl/reg_write_arbiter.sv | 115 +++++++++++
 tb/tb_reg_write_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Round-robin arbiter that shares the single write port of the CPU register
//   bank between N_REQ write sources. One winner is chosen per clock. The
//   bank-side write strobe, address and data are registered, and the winner
//   gets a one-cycle registered ack.
//
// Ports
//   clk      : system clock, all state updates on the rising edge
//   reset    : synchronous, active-high reset
//   req      : per-requester write request (bit i = requester i)
//   req_addr : flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data : flattened data, requester i at [i*WIDTH +: WIDTH]
//   ack      : one-hot, one-cycle pulse to the requester whose write was taken
//   wr_en    : registered write strobe to the register bank
//   wr_addr  : registered write address (holds its value while idle)
//   wr_data  : registered write data (holds its value while idle)
//   busy     : registered, high in every cycle where wr_en is high
module reg_write_arbiter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned N_REQ  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*WIDTH-1:0]  req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [WIDTH-1:0]        wr_data,
    output logic                    busy
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  ack_q,     ack_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic              busy_q,    busy_d;
    logic [PTR_W-1:0]  ptr_q,     ptr_d;

    logic [N_REQ-1:0]  eligible;
    logic              found;
    int unsigned       win_i;
    int unsigned       idx;

    // A requester that is being acked this cycle may still show req high
    // while it reacts; masking it avoids a second grant of the same write.
    assign eligible = req & ~ack_q;

    // Scan ptr, ptr+1, ..., wrapping past N_REQ-1 back to 0; first hit wins.
    always_comb begin
        found = 1'b0;
        win_i = 0;
        idx   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win_i = idx;
            end
        end
    end

    always_comb begin
        ack_d     = '0;
        wr_en_d   = 1'b0;
        busy_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ptr_d     = ptr_q;
        if (found) begin
            ack_d[win_i] = 1'b1;
            wr_en_d      = 1'b1;
            busy_d       = 1'b1;
            wr_addr_d    = req_addr[win_i*ADDR_W +: ADDR_W];
            wr_data_d    = req_data[win_i*WIDTH +: WIDTH];
            if (win_i == N_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = PTR_W'(win_i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
        end else begin
            ack_q     <= ack_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
        end
    end

    assign ack     = ack_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 2;
    localparam int N_REQ  = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*WIDTH-1:0]  req_data;
    logic [N_REQ-1:0]        ack;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [WIDTH-1:0]        wr_data;
    logic                    busy;

    int tests = 0;
    int fails = 0;

    // Downstream register bank, fed from the DUT write port.
    logic [WIDTH-1:0] bank [4];

    reg_write_arbiter #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .N_REQ  (N_REQ)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en === 1'b1) bank[wr_addr] <= wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: plain integer pointer and modular scan.
    int              m_ptr;
    int              m_win;
    bit              m_valid = 0;
    logic [N_REQ-1:0] m_ack;
    logic            m_wr_en;
    logic [ADDR_W-1:0] m_addr;
    logic [WIDTH-1:0]  m_data;
    logic [N_REQ-1:0] m_elig;

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_valid = 1;
            m_ptr   = 0;
            m_ack   = '0;
            m_wr_en = 1'b0;
            m_addr  = '0;
            m_data  = '0;
        end else if (m_valid) begin
            m_elig = req & ~m_ack;
            m_win  = -1;
            for (int k = 0; k < N_REQ; k++) begin
                if (m_win < 0 && m_elig[(m_ptr + k) % N_REQ]) m_win = (m_ptr + k) % N_REQ;
            end
            if (m_win < 0) begin
                m_ack   = '0;
                m_wr_en = 1'b0;
            end else begin
                m_ack   = N_REQ'(1) << m_win;
                m_wr_en = 1'b1;
                m_addr  = req_addr[m_win*ADDR_W +: ADDR_W];
                m_data  = req_data[m_win*WIDTH +: WIDTH];
                m_ptr   = (m_win + 1) % N_REQ;
            end
        end
        #1;
        if (m_valid) begin
            chk("model_ack",     32'(ack),     32'(m_ack));
            chk("model_wr_en",   32'(wr_en),   32'(m_wr_en));
            chk("model_busy",    32'(busy),    32'(m_wr_en));
            chk("model_wr_addr", 32'(wr_addr), 32'(m_addr));
            chk("model_wr_data", 32'(wr_data), 32'(m_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_src(input int i, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*WIDTH +: WIDTH]   = d;
    endtask

    task automatic expect_out(input string name, input logic [N_REQ-1:0] e_ack,
                              input logic e_en, input logic [WIDTH-1:0] e_data);
        chk({name, "_ack"},   32'(ack),   32'(e_ack));
        chk({name, "_wr_en"}, 32'(wr_en), 32'(e_en));
        chk({name, "_busy"},  32'(busy),  32'(e_en));
        if (e_en) chk({name, "_wr_data"}, 32'(wr_data), 32'(e_data));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bank[i] = '0;
        reset = 1'b1;
        req   = 3'b111;
        req_addr = '0;
        req_data = '0;
        set_src(0, 2'd0, 8'h11);
        set_src(1, 2'd1, 8'h22);
        set_src(2, 2'd2, 8'h33);

        // Reset held for two edges with all requests high.
        step();
        step();
        chk("rst_ack",     32'(ack),     32'h0);
        chk("rst_wr_en",   32'(wr_en),   32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        chk("rst_busy",    32'(busy),    32'h0);

        // Full load round robin, starting at requester 0.
        reset = 1'b0;
        step(); expect_out("rr0", 3'b001, 1'b1, 8'h11);
        chk("rr0_wr_addr", 32'(wr_addr), 32'd0);
        step(); expect_out("rr1", 3'b010, 1'b1, 8'h22);
        step(); expect_out("rr2", 3'b100, 1'b1, 8'h33);
        chk("rr2_wr_addr", 32'(wr_addr), 32'd2);
        step(); expect_out("rr3", 3'b001, 1'b1, 8'h11);
        req = 3'b000;
        step(); expect_out("idle", 3'b000, 1'b0, 8'h00);
        chk("idle_hold_data", 32'(wr_data), 32'h11);

        // Only requester 2 held high: grants every other cycle.
        set_src(2, 2'd2, 8'h5C);
        req = 3'b100;
        step(); expect_out("hold0", 3'b100, 1'b1, 8'h5C);
        step(); expect_out("hold1", 3'b000, 1'b0, 8'h00);
        step(); expect_out("hold2", 3'b100, 1'b1, 8'h5C);
        step(); expect_out("hold3", 3'b000, 1'b0, 8'h00);
        req = 3'b000;
        step();

        // Single request, dropped on ack.
        set_src(1, 2'd2, 8'hAA);
        req = 3'b010;
        step(); expect_out("single", 3'b010, 1'b1, 8'hAA);
        chk("single_wr_addr", 32'(wr_addr), 32'd2);
        req = 3'b000;
        step(); expect_out("single_drop", 3'b000, 1'b0, 8'h00);

        // Withdrawal / pointer: grant 0, then 2 wins over 0.
        req = 3'b001;
        step(); expect_out("wd0", 3'b001, 1'b1, 8'h11);
        req = 3'b101;
        step(); expect_out("wd1", 3'b100, 1'b1, 8'h5C);
        req = 3'b001;
        step(); expect_out("wd2", 3'b001, 1'b1, 8'h11);
        req = 3'b000;
        step();
        // ptr now 1: with 0 and 2 both eligible, 2 is first.
        req = 3'b101;
        step(); expect_out("ptr1", 3'b100, 1'b1, 8'h5C);
        req = 3'b001;
        step(); expect_out("ptr2", 3'b001, 1'b1, 8'h11);
        req = 3'b000;
        step();

        // Reset on the edge a grant would be registered.
        set_src(0, 2'd3, 8'h77);
        req   = 3'b001;
        reset = 1'b1;
        step(); expect_out("rst_mid", 3'b000, 1'b0, 8'h00);
        reset = 1'b0;
        req   = 3'b000;
        step();
        step();
        chk("bank3_untouched", 32'(bank[3]), 32'h00);

        // Pointer back at 0 after reset.
        req = 3'b011;
        set_src(0, 2'd0, 8'h11);
        step(); expect_out("post_rst", 3'b001, 1'b1, 8'h11);
        req = 3'b000;
        step();
        step();
        chk("bank0", 32'(bank[0]), 32'h11);
        chk("bank2", 32'(bank[2]), 32'h5C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
